// File: rtl/ix_stage_pkg.sv
// Shared encodings and the writeback entry layout for the RISu64 integer execute stage.
package ix_stage_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SR   = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_EQ   = 4'd8;

  localparam logic ALUOPT_SUB = 1'b1;
  localparam logic ALUOPT_SRA = 1'b1;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_type_e;

  typedef struct packed {
    logic [XLEN-1:0] value;
    logic [4:0]      dst;
    logic            wb_en;
    logic [XLEN-1:0] pc;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            misalign;
  } wb_entry_t;

endpackage

// File: rtl/ix_stage_alu.sv
// Combinational 64-bit integer ALU; W-variant narrowing is handled by the caller.
module ix_stage_alu
  import ix_stage_pkg::*;
(
  input  logic [3:0]      i_op,
  input  logic            i_option,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y
);

  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic [5:0]             w_shamt;

  assign w_a_s   = i_a;
  assign w_b_s   = i_b;
  assign w_shamt = i_b[5:0];

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = (i_option == ALUOPT_SUB) ? (i_a - i_b) : (i_a + i_b);
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SLT:  o_y = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
      ALU_SLTU: o_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SR: begin
        if (i_option == ALUOPT_SRA) o_y = w_a_s >>> w_shamt;
        else                        o_y = i_a >> w_shamt;
      end
      ALU_OR:   o_y = i_a | i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_EQ:   o_y = {{(XLEN-1){1'b0}}, (i_a == i_b)};
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/ix_stage.sv
// Integer execute stage: operand prep, ALU, branch resolution and a 2-entry
// elastic output buffer (out + skid) toward writeback.
module ix_stage
  import ix_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ix_valid,
  output logic            ix_ready,
  input  logic [XLEN-1:0] ix_pc,
  input  logic [3:0]      ix_op,
  input  logic            ix_option,
  input  logic            ix_truncate,
  input  logic            ix_op1_pc,
  input  logic            ix_op2_imm,
  input  logic [XLEN-1:0] ix_rs1,
  input  logic [XLEN-1:0] ix_rs2,
  input  logic [XLEN-1:0] ix_imm,
  input  logic [1:0]      ix_br_type,
  input  logic            ix_br_neg,
  input  logic [4:0]      ix_dst,
  input  logic            ix_wb_en,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_value,
  output logic [4:0]      wb_dst,
  output logic            wb_wb_en,
  output logic [XLEN-1:0] wb_pc,
  output logic            wb_br_taken,
  output logic [XLEN-1:0] wb_br_target,
  output logic            wb_misalign
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  br_type_e        w_br_p0;
  logic [XLEN-1:0] w_op1_p0;
  logic [XLEN-1:0] w_op2_p0;
  logic [XLEN-1:0] w_alu_a_p0;
  logic [XLEN-1:0] w_alu_b_p0;
  logic [XLEN-1:0] w_alu_y_p0;
  logic [XLEN-1:0] w_result_p0;
  logic [XLEN-1:0] w_tgt_base_p0;
  logic [XLEN-1:0] w_tgt_sum_p0;
  logic [XLEN-1:0] w_target_p0;
  logic [XLEN-1:0] w_link_p0;
  logic            w_taken_p0;
  wb_entry_t       w_ent_p0;

  wb_entry_t       r_out_p1;
  wb_entry_t       r_skid_p1;
  logic            r_out_vld_p1;
  logic            r_skid_vld_p1;
  logic            w_accept;
  logic            w_drain;
  logic            w_out_free;

  // ---- stage p0: operand prep, ALU, branch resolution ----
  assign w_br_p0 = br_type_e'(ix_br_type);

  // W shifts use a 5-bit shamt; SRW/SRAW see a zero/sign-extended low word.
  always_comb begin
    w_op1_p0   = ix_op1_pc  ? ix_pc  : ix_rs1;
    w_op2_p0   = ix_op2_imm ? ix_imm : ix_rs2;
    w_alu_a_p0 = w_op1_p0;
    w_alu_b_p0 = w_op2_p0;
    if (ix_truncate && (ix_op == ALU_SLL || ix_op == ALU_SR))
      w_alu_b_p0[5] = 1'b0;
    if (ix_truncate && ix_op == ALU_SR)
      w_alu_a_p0 = {{32{w_op1_p0[31] & (ix_option == ALUOPT_SRA)}}, w_op1_p0[31:0]};
  end

  ix_stage_alu alu (
    .i_op     (ix_op),
    .i_option (ix_option),
    .i_a      (w_alu_a_p0),
    .i_b      (w_alu_b_p0),
    .o_y      (w_alu_y_p0)
  );

  assign w_result_p0   = ix_truncate ? sext32(w_alu_y_p0[31:0]) : w_alu_y_p0;
  assign w_tgt_base_p0 = (w_br_p0 == BR_JALR) ? ix_rs1 : ix_pc;
  assign w_tgt_sum_p0  = w_tgt_base_p0 + ix_imm;
  assign w_target_p0   = (w_br_p0 == BR_JALR) ? {w_tgt_sum_p0[XLEN-1:1], 1'b0} : w_tgt_sum_p0;
  assign w_link_p0     = ix_pc + 64'd4;

  always_comb begin
    case (w_br_p0)
      BR_COND:         w_taken_p0 = w_result_p0[0] ^ ix_br_neg;
      BR_JAL, BR_JALR: w_taken_p0 = 1'b1;
      default:         w_taken_p0 = 1'b0;
    endcase
  end

  always_comb begin
    w_ent_p0           = '0;
    w_ent_p0.value     = (w_br_p0 == BR_JAL || w_br_p0 == BR_JALR) ? w_link_p0 : w_result_p0;
    w_ent_p0.dst       = ix_dst;
    w_ent_p0.wb_en     = (w_br_p0 == BR_COND) ? 1'b0 : ix_wb_en;
    w_ent_p0.pc        = ix_pc;
    w_ent_p0.br_taken  = w_taken_p0;
    w_ent_p0.br_target = w_target_p0;
    w_ent_p0.misalign  = w_taken_p0 & w_target_p0[1];
  end

  // ---- stage p1: out/skid buffer toward writeback ----
  assign ix_ready   = !rst && !r_skid_vld_p1;
  assign w_accept   = ix_valid && ix_ready && !flush;
  assign w_drain    = r_out_vld_p1 && wb_ready;
  assign w_out_free = !r_out_vld_p1 || w_drain;

  // ix_ready excludes accept while skid is full, so skid and a new entry never compete for out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld_p1  <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (flush) begin
      r_out_vld_p1  <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (w_out_free) begin
      r_out_vld_p1  <= r_skid_vld_p1 || w_accept;
      r_skid_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_p1 <= '0;
    end else if (!flush && w_out_free) begin
      if (r_skid_vld_p1) r_out_p1 <= r_skid_p1;
      else if (w_accept) r_out_p1 <= w_ent_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_out_free) r_skid_p1 <= w_ent_p0;
  end

  assign wb_valid     = r_out_vld_p1;
  assign wb_value     = r_out_p1.value;
  assign wb_dst       = r_out_p1.dst;
  assign wb_wb_en     = r_out_p1.wb_en;
  assign wb_pc        = r_out_p1.pc;
  assign wb_br_taken  = r_out_p1.br_taken;
  assign wb_br_target = r_out_p1.br_target;
  assign wb_misalign  = r_out_p1.misalign;

endmodule

// File: tb/tb_ix_stage.sv
// Bench for ix_stage: directed vector table, hand-written backpressure/flush/reset
// sequences, and randomized traffic against a behavioural queue model.
module tb_ix_stage;
  import ix_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, ix_valid, ix_ready;
  logic [63:0] ix_pc, ix_rs1, ix_rs2, ix_imm;
  logic [3:0]  ix_op;
  logic        ix_option, ix_truncate, ix_op1_pc, ix_op2_imm, ix_br_neg, ix_wb_en;
  logic [1:0]  ix_br_type;
  logic [4:0]  ix_dst;
  logic        wb_valid, wb_ready, wb_wb_en, wb_br_taken, wb_misalign;
  logic [63:0] wb_value, wb_pc, wb_br_target;
  logic [4:0]  wb_dst;

  always #5 clk = ~clk;

  ix_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ix_valid(ix_valid), .ix_ready(ix_ready), .ix_pc(ix_pc), .ix_op(ix_op),
    .ix_option(ix_option), .ix_truncate(ix_truncate), .ix_op1_pc(ix_op1_pc),
    .ix_op2_imm(ix_op2_imm), .ix_rs1(ix_rs1), .ix_rs2(ix_rs2), .ix_imm(ix_imm),
    .ix_br_type(ix_br_type), .ix_br_neg(ix_br_neg), .ix_dst(ix_dst), .ix_wb_en(ix_wb_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_value(wb_value), .wb_dst(wb_dst),
    .wb_wb_en(wb_wb_en), .wb_pc(wb_pc), .wb_br_taken(wb_br_taken),
    .wb_br_target(wb_br_target), .wb_misalign(wb_misalign)
  );

  typedef struct {
    logic [63:0] pc; logic [3:0] op; logic opt; logic trunc; logic op1_pc; logic op2_imm;
    logic [63:0] rs1; logic [63:0] rs2; logic [63:0] imm; logic [1:0] br; logic neg;
    logic [4:0] dst; logic wb_en;
  } in_t;

  typedef struct {
    logic [63:0] value; logic taken; logic [63:0] target; logic wb_en; logic misalign;
    logic [4:0] dst; logic [63:0] pc; logic [1:0] br;
  } exp_t;

  typedef struct { string name; in_t in; exp_t exp; } vec_t;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".taken"},    wb_br_taken, e.taken);
    chk({tag, ".misalign"}, wb_misalign, e.misalign);
    chk({tag, ".wb_en"},    wb_wb_en,    e.wb_en);
    chk({tag, ".dst"},      wb_dst,      e.dst);
    chk({tag, ".pc"},       wb_pc,       e.pc);
    if (e.br != BR_COND) chk({tag, ".value"},  wb_value,     e.value);
    if (e.br != BR_NONE) chk({tag, ".target"}, wb_br_target, e.target);
  endtask

  task automatic drive(input in_t v);
    ix_pc = v.pc; ix_op = v.op; ix_option = v.opt; ix_truncate = v.trunc;
    ix_op1_pc = v.op1_pc; ix_op2_imm = v.op2_imm; ix_rs1 = v.rs1; ix_rs2 = v.rs2;
    ix_imm = v.imm; ix_br_type = v.br; ix_br_neg = v.neg; ix_dst = v.dst; ix_wb_en = v.wb_en;
  endtask

  function automatic in_t mkin(input logic [63:0] pc, input logic [3:0] op, input logic opt,
                               input logic trunc, input logic op1_pc, input logic op2_imm,
                               input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic [63:0] imm, input logic [1:0] br, input logic neg);
    in_t v;
    v.pc = pc; v.op = op; v.opt = opt; v.trunc = trunc; v.op1_pc = op1_pc; v.op2_imm = op2_imm;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.br = br; v.neg = neg; v.dst = 5'd7; v.wb_en = 1'b1;
    return v;
  endfunction

  function automatic exp_t mkexp(input logic [63:0] value, input logic taken,
                                 input logic [63:0] target, input logic wb_en,
                                 input logic misalign, input in_t v);
    exp_t e;
    e.value = value; e.taken = taken; e.target = target; e.wb_en = wb_en;
    e.misalign = misalign; e.dst = v.dst; e.pc = v.pc; e.br = v.br;
    return e;
  endfunction

  // Full-width RV64 semantics of each ALU operation.
  function automatic logic [63:0] alu64(input logic [3:0] op, input logic opt,
                                        input logic [63:0] a, input logic [63:0] b);
    longint      sa = a;
    longint      sb = b;
    int unsigned sh = b[5:0];
    if (op == ALU_ADD && opt)  return a - b;
    if (op == ALU_ADD)         return a + b;
    if (op == ALU_SLL)         return a << sh;
    if (op == ALU_SLT)         return (sa < sb) ? 64'd1 : 64'd0;
    if (op == ALU_SLTU)        return (a < b) ? 64'd1 : 64'd0;
    if (op == ALU_XOR)         return a ^ b;
    if (op == ALU_SR && opt)   return sa >>> sh;
    if (op == ALU_SR)          return a >> sh;
    if (op == ALU_OR)          return a | b;
    if (op == ALU_AND)         return a & b;
    if (op == ALU_EQ)          return (a == b) ? 64'd1 : 64'd0;
    return 64'd0;
  endfunction

  // W-variants computed natively on 32-bit words, then sign-extended.
  function automatic exp_t model(input in_t v);
    exp_t        e;
    logic [63:0] a, b, res;
    logic [31:0] a32, b32, r32;
    int unsigned sh;
    a = v.op1_pc ? v.pc : v.rs1;
    b = v.op2_imm ? v.imm : v.rs2;
    if (v.trunc) begin
      a32 = a[31:0]; b32 = b[31:0]; sh = b[4:0];
      if (v.op == ALU_ADD && v.opt)     r32 = a32 - b32;
      else if (v.op == ALU_ADD)         r32 = a32 + b32;
      else if (v.op == ALU_SLL)         r32 = a32 << sh;
      else if (v.op == ALU_SR && v.opt) r32 = $signed(a32) >>> sh;
      else if (v.op == ALU_SR)          r32 = a32 >> sh;
      else begin res = alu64(v.op, v.opt, a, b); r32 = res[31:0]; end
      res = {{32{r32[31]}}, r32};
    end else begin
      res = alu64(v.op, v.opt, a, b);
    end
    e.br = v.br; e.pc = v.pc; e.dst = v.dst; e.value = res; e.taken = 1'b0;
    e.target = v.pc + v.imm; e.wb_en = v.wb_en;
    case (v.br)
      BR_COND: begin e.taken = res[0] ^ v.neg; e.wb_en = 1'b0; end
      BR_JAL:  begin e.taken = 1'b1; e.value = v.pc + 64'd4; end
      BR_JALR: begin e.taken = 1'b1; e.value = v.pc + 64'd4; e.target = (v.rs1 + v.imm) & ~64'd1; end
      default: ;
    endcase
    e.misalign = e.taken & e.target[1];
    return e;
  endfunction

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h0000_0000_7FFF_FFFF;
      3: return 64'h0000_0000_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic in_t rand_in();
    in_t v;
    logic [3:0] ops[9];
    logic [3:0] cmps[3];
    ops  = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SR, ALU_OR, ALU_AND, ALU_EQ};
    cmps = '{ALU_SLT, ALU_SLTU, ALU_EQ};
    v.pc = {$urandom, $urandom}; v.rs1 = rand_val(); v.rs2 = rand_val(); v.imm = rand_val();
    v.op = ops[$urandom_range(0, 8)]; v.opt = 1'($urandom_range(0, 1));
    v.trunc = 1'($urandom_range(0, 1)); v.op1_pc = ($urandom_range(0, 3) == 0);
    v.op2_imm = 1'($urandom_range(0, 1)); v.br = 2'($urandom_range(0, 3));
    v.neg = 1'($urandom_range(0, 1)); v.dst = 5'($urandom_range(0, 31));
    v.wb_en = 1'($urandom_range(0, 1));
    if (v.br == BR_COND) begin
      v.op = cmps[$urandom_range(0, 2)]; v.trunc = 1'b0; v.op1_pc = 1'b0; v.op2_imm = 1'b0;
    end
    return v;
  endfunction

  vec_t vecs[11];
  in_t  v;
  in_t  idle;

  initial begin
    idle = mkin(64'h0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, BR_NONE, 1'b0);
    rst = 1'b1; flush = 1'b0; ix_valid = 1'b0; wb_ready = 1'b0;
    drive(idle);

    vecs[0].in  = mkin(64'h100, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'h0, 64'h1, BR_NONE, 1'b0);
    vecs[0].exp = mkexp(64'hFFFF_FFFF_8000_0000, 1'b0, 64'h0, 1'b1, 1'b0, vecs[0].in);
    vecs[0].name = "addw_ovf";
    vecs[1].in  = mkin(64'h104, ALU_SR, 1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0000, 64'h0, 64'h24, BR_NONE, 1'b0);
    vecs[1].exp = mkexp(64'hFFFF_FFFF_F800_0000, 1'b0, 64'h0, 1'b1, 1'b0, vecs[1].in);
    vecs[1].name = "sraw";
    vecs[2].in  = mkin(64'h108, ALU_SR, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0000, 64'h0, 64'h24, BR_NONE, 1'b0);
    vecs[2].exp = mkexp(64'h0000_0000_0800_0000, 1'b0, 64'h0, 1'b1, 1'b0, vecs[2].in);
    vecs[2].name = "srlw";
    vecs[3].in  = mkin(64'h8000_0000, ALU_SLT, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h10, BR_COND, 1'b0);
    vecs[3].exp = mkexp(64'h1, 1'b1, 64'h8000_0010, 1'b0, 1'b0, vecs[3].in);
    vecs[3].name = "blt";
    vecs[4].in  = mkin(64'h8000_0000, ALU_SLT, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h10, BR_COND, 1'b1);
    vecs[4].exp = mkexp(64'h1, 1'b0, 64'h8000_0010, 1'b0, 1'b0, vecs[4].in);
    vecs[4].name = "bge";
    vecs[5].in  = mkin(64'h2000, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1003, 64'h0, 64'h0, BR_JALR, 1'b0);
    vecs[5].exp = mkexp(64'h2004, 1'b1, 64'h1002, 1'b1, 1'b1, vecs[5].in);
    vecs[5].name = "jalr";
    vecs[6].in  = mkin(64'h4000, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0, 64'h0, 64'h100, BR_JAL, 1'b0);
    vecs[6].exp = mkexp(64'h4004, 1'b1, 64'h4100, 1'b1, 1'b0, vecs[6].in);
    vecs[6].name = "jal";
    vecs[7].in  = mkin(64'h200, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 64'h5, 64'h7, 64'h0, BR_NONE, 1'b0);
    vecs[7].exp = mkexp(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0, 1'b1, 1'b0, vecs[7].in);
    vecs[7].name = "sub";
    vecs[8].in  = mkin(64'h1000, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0, 64'h0, 64'h2000, BR_NONE, 1'b0);
    vecs[8].exp = mkexp(64'h3000, 1'b0, 64'h0, 1'b1, 1'b0, vecs[8].in);
    vecs[8].name = "auipc";
    vecs[9].in  = mkin(64'h204, ALU_SLL, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1, 64'h0, 64'h3F, BR_NONE, 1'b0);
    vecs[9].exp = mkexp(64'hFFFF_FFFF_8000_0000, 1'b0, 64'h0, 1'b1, 1'b0, vecs[9].in);
    vecs[9].name = "sllw";
    vecs[10].in  = mkin(64'h208, ALU_SR, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h0, 64'h24, BR_NONE, 1'b0);
    vecs[10].exp = mkexp(64'hFFFF_FFFF_F800_0000, 1'b0, 64'h0, 1'b1, 1'b0, vecs[10].in);
    vecs[10].name = "sra64";

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ix_ready", ix_ready, 0);
    chk("rst.wb_valid", wb_valid, 0);
    chk("rst.wb_value", wb_value, 0);
    chk("rst.wb_target", wb_br_target, 0);
    chk("rst.wb_pc", wb_pc, 0);
    rst = 1'b0;
    #1 chk("rst.release_ready", ix_ready, 1);

    // Directed table, one op per cycle with writeback always ready
    wb_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].in); ix_valid = 1'b1;
      @(negedge clk);
      ix_valid = 1'b0;
      chk({vecs[i].name, ".valid"}, wb_valid, 1);
      chk_out(vecs[i].name, vecs[i].exp);
    end
    @(negedge clk);
    chk("idle.wb_valid", wb_valid, 0);

    // Backpressure: three ops offered while writeback stalls three cycles
    wb_ready = 1'b0;
    drive(mkin(64'h300, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 64'h0, 64'h0, BR_NONE, 1'b0));
    ix_valid = 1'b1;
    @(negedge clk);
    chk("bp.ready_a", ix_ready, 1);
    drive(mkin(64'h304, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h22, 64'h0, 64'h0, BR_NONE, 1'b0));
    @(negedge clk);
    chk("bp.ready_full", ix_ready, 0);
    chk("bp.out_a", wb_value, 64'h11);
    drive(mkin(64'h308, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h33, 64'h0, 64'h0, BR_NONE, 1'b0));
    @(negedge clk);
    chk("bp.ready_hold", ix_ready, 0);
    chk("bp.stable_a", wb_value, 64'h11);
    chk("bp.stable_pc", wb_pc, 64'h300);
    wb_ready = 1'b1;
    @(negedge clk);
    chk("bp.valid_b", wb_valid, 1);
    chk("bp.out_b", wb_value, 64'h22);
    chk("bp.ready_rise", ix_ready, 1);
    @(negedge clk);
    ix_valid = 1'b0;
    chk("bp.out_c", wb_value, 64'h33);
    chk("bp.valid_c", wb_valid, 1);
    @(negedge clk);
    chk("bp.drained", wb_valid, 0);

    // Flush with both entries held and an op offered
    wb_ready = 1'b0;
    drive(mkin(64'h400, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h44, 64'h0, 64'h0, BR_NONE, 1'b0));
    ix_valid = 1'b1;
    @(negedge clk);
    drive(mkin(64'h404, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h55, 64'h0, 64'h0, BR_NONE, 1'b0));
    @(negedge clk);
    chk("fl.full", ix_ready, 0);
    drive(mkin(64'h408, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h66, 64'h0, 64'h0, BR_NONE, 1'b0));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ix_valid = 1'b0; wb_ready = 1'b1;
    chk("fl.valid", wb_valid, 0);
    chk("fl.ready", ix_ready, 1);
    repeat (2) begin
      @(negedge clk);
      chk("fl.no_ghost", wb_valid, 0);
    end

    // Reset mid-operation
    wb_ready = 1'b0;
    drive(mkin(64'h500, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h77, 64'h0, 64'h0, BR_NONE, 1'b0));
    ix_valid = 1'b1;
    @(negedge clk);
    drive(mkin(64'h504, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 64'h88, 64'h0, 64'h0, BR_NONE, 1'b0));
    @(negedge clk);
    ix_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rmid.valid", wb_valid, 0);
    chk("rmid.ready", ix_ready, 0);
    chk("rmid.value", wb_value, 0);
    rst = 1'b0;
    #1 chk("rmid.ready_rel", ix_ready, 1);

    // Randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd.wb_valid", wb_valid, (q.size() != 0));
      chk("rnd.ix_ready", ix_ready, (q.size() < 2));
      v = rand_in();
      drive(v);
      ix_valid = ($urandom_range(0, 3) != 0);
      wb_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 40) == 0);
      #1;
      if (wb_valid && wb_ready && q.size() != 0) begin
        chk_out("rnd", q[0]);
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (ix_valid && ix_ready) q.push_back(model(v));
    end
    @(negedge clk);
    flush = 1'b0; ix_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
